// File: rtl/mem_port_arbiter.sv
// Shared memory-bus arbiter for the F-stage fetch port and the M-stage data port.
// Optional ARB_RR_EN selects round-robin instead of fixed data-first arbitration.
module mem_port_arbiter #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inst_req,
    input  logic [AW-1:0] inst_addr,
    output logic [DW-1:0] inst_rdata,
    output logic          inst_ack,
    input  logic          data_req,
    input  logic          data_wr,
    input  logic [AW-1:0] data_addr,
    input  logic [DW-1:0] data_wdata,
    output logic [DW-1:0] data_rdata,
    output logic          data_ack,
    output logic          bus_req,
    output logic          bus_wr,
    output logic [AW-1:0] bus_addr,
    output logic [DW-1:0] bus_wdata,
    input  logic [DW-1:0] bus_rdata,
    input  logic          bus_ack,
    output logic          bus_err
);

    typedef enum logic [1:0] {StIdle, StBusy, StResp} stateT;

    localparam logic [15:0] CntLast = 16'(TIMEOUT - 1);

    stateT         stateQ, stateD;
    logic [15:0]   cntQ, cntD;
    logic          grantQ, grantD;
    logic          grantSel;
    logic          anyReq;
    logic          busReqD, busWrD, busErrD, instAckD, dataAckD;
    logic [AW-1:0] busAddrD;
    logic [DW-1:0] busWdataD, instRdataD, dataRdataD;

    assign anyReq = inst_req | data_req;

`ifdef ARB_RR_EN
    logic lastGrantQ;

    // On a conflict the port not granted last wins; history starts at inst.
    always_comb grantSel = (inst_req && data_req) ? ~lastGrantQ : data_req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lastGrantQ <= 1'b0;
        end else if (stateQ == StIdle && anyReq) begin
            lastGrantQ <= grantSel;
        end
    end
`else
    always_comb grantSel = data_req;
`endif

    always_comb begin
        stateD     = stateQ;
        cntD       = cntQ;
        grantD     = grantQ;
        busReqD    = bus_req;
        busWrD     = bus_wr;
        busAddrD   = bus_addr;
        busWdataD  = bus_wdata;
        instRdataD = inst_rdata;
        dataRdataD = data_rdata;
        instAckD   = 1'b0;
        dataAckD   = 1'b0;
        busErrD    = 1'b0;
        case (stateQ)
            StIdle: begin
                if (anyReq) begin
                    stateD    = StBusy;
                    grantD    = grantSel;
                    busReqD   = 1'b1;
                    busWrD    = grantSel & data_wr;
                    busAddrD  = grantSel ? data_addr : inst_addr;
                    busWdataD = grantSel ? data_wdata : '0;
                    cntD      = '0;
                end
            end
            StBusy: begin
                // A bus_ack in the final window cycle takes precedence over the abort.
                if (bus_ack || cntQ == CntLast) begin
                    stateD   = StResp;
                    busReqD  = 1'b0;
                    instAckD = ~grantQ;
                    dataAckD = grantQ;
                    busErrD  = ~bus_ack;
                    if (!grantQ) begin
                        instRdataD = bus_ack ? bus_rdata : '0;
                    end else if (!bus_wr) begin
                        dataRdataD = bus_ack ? bus_rdata : '0;
                    end
                end else begin
                    cntD = cntQ + 16'd1;
                end
            end
            StResp:  stateD = StIdle;
            default: stateD = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ     <= StIdle;
            cntQ       <= '0;
            grantQ     <= 1'b0;
            bus_req    <= 1'b0;
            bus_wr     <= 1'b0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
            bus_err    <= 1'b0;
            inst_rdata <= '0;
            data_rdata <= '0;
            inst_ack   <= 1'b0;
            data_ack   <= 1'b0;
        end else begin
            stateQ     <= stateD;
            cntQ       <= cntD;
            grantQ     <= grantD;
            bus_req    <= busReqD;
            bus_wr     <= busWrD;
            bus_addr   <= busAddrD;
            bus_wdata  <= busWdataD;
            bus_err    <= busErrD;
            inst_rdata <= instRdataD;
            data_rdata <= dataRdataD;
            inst_ack   <= instAckD;
            data_ack   <= dataAckD;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (TIMEOUT = 8).
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inst_req = 1'b0;
    logic [31:0] inst_addr = '0;
    logic [31:0] inst_rdata;
    logic        inst_ack;
    logic        data_req = 1'b0;
    logic        data_wr = 1'b0;
    logic [31:0] data_addr = '0;
    logic [31:0] data_wdata = '0;
    logic [31:0] data_rdata;
    logic        data_ack;
    logic        bus_req;
    logic        bus_wr;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata = '0;
    logic        bus_ack = 1'b0;
    logic        bus_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int riseCyc = 0;
    logic [31:0] lastData = '0;

    mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata),
        .inst_ack(inst_ack),
        .data_req(data_req), .data_wr(data_wr), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_rdata(data_rdata), .data_ack(data_ack),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_err(bus_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts in IDLE with requests already driven; returns in the RESP cycle.
    task automatic doTxn(input string tag, input logic expData, input logic expWr,
                         input logic [31:0] expAddr, input logic [31:0] expWdata,
                         input logic [31:0] rd, input int lat);
        tick();
        riseCyc = cyc;
        checkVal({tag, " bus_req"}, bus_req, 1);
        checkVal({tag, " bus_addr"}, bus_addr, expAddr);
        checkVal({tag, " bus_wr"}, bus_wr, expWr);
        checkVal({tag, " bus_wdata"}, bus_wdata, expWdata);
        for (int i = 1; i < lat; i++) begin
            tick();
            checkVal({tag, " hold bus_req"}, bus_req, 1);
            checkVal({tag, " hold bus_addr"}, bus_addr, expAddr);
        end
        bus_ack = 1'b1;
        bus_rdata = rd;
        tick();
        bus_ack = 1'b0;
        bus_rdata = '0;
        checkVal({tag, " ack"}, expData ? data_ack : inst_ack, 1);
        checkVal({tag, " other ack"}, expData ? inst_ack : data_ack, 0);
        checkVal({tag, " bus_req resp"}, bus_req, 0);
        checkVal({tag, " bus_err"}, bus_err, 0);
        if (expData) begin
            if (!expWr) lastData = rd;
            checkVal({tag, " data_rdata"}, data_rdata, lastData);
        end else begin
            checkVal({tag, " inst_rdata"}, inst_rdata, rd);
        end
    endtask

    initial begin
        logic expG [4];
        logic [31:0] a;
        int n;
        int prevRise;

        // Reset values
        #2;
        checkVal("rst inst_ack", inst_ack, 0);
        checkVal("rst data_ack", data_ack, 0);
        checkVal("rst inst_rdata", inst_rdata, 0);
        checkVal("rst data_rdata", data_rdata, 0);
        checkVal("rst bus_req", bus_req, 0);
        checkVal("rst bus_wr", bus_wr, 0);
        checkVal("rst bus_addr", bus_addr, 0);
        checkVal("rst bus_wdata", bus_wdata, 0);
        checkVal("rst bus_err", bus_err, 0);
        tick();
        rst = 1'b0;
        tick();

        // Single fetch
        inst_req = 1'b1;
        inst_addr = 32'hBFC0_0000;
        doTxn("fetch", 1'b0, 1'b0, 32'hBFC0_0000, 32'h0, 32'h3C08_0001, 1);
        inst_req = 1'b0;
        tick();
        checkVal("fetch ack drop", inst_ack, 0);

        // Conflict, both held, starting from reset history
        rst = 1'b1;
        #2;
        rst = 1'b0;
        lastData = '0;
        tick();
`ifdef ARB_RR_EN
        expG = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        expG = '{1'b1, 1'b1, 1'b1, 1'b0};
`endif
        inst_req = 1'b1;
        inst_addr = 32'h0000_0100;
        data_req = 1'b1;
        data_wr = 1'b0;
        data_addr = 32'h0000_0200;
        for (int k = 0; k < 4; k++) begin
            a = expG[k] ? 32'h0000_0200 : 32'h0000_0100;
            doTxn($sformatf("conflict%0d", k), expG[k], 1'b0, a, 32'h0, 32'hA000_0000 + k, 1);
            if (k == 2) data_req = 1'b0;
            if (k == 3) inst_req = 1'b0;
            tick();
        end

        // Data write leaves data_rdata untouched
        data_req = 1'b1;
        data_wr = 1'b1;
        data_addr = 32'h8000_1000;
        data_wdata = 32'hDEAD_BEEF;
        doTxn("write", 1'b1, 1'b1, 32'h8000_1000, 32'hDEAD_BEEF, 32'h1234_5678, 3);
        data_req = 1'b0;
        data_wr = 1'b0;
        tick();

        // Timeout with no bus_ack
        data_req = 1'b1;
        data_addr = 32'h0000_0300;
        n = 0;
        tick();
        while (bus_req === 1'b1 && n < 20) begin
            n++;
            tick();
        end
        checkVal("timeout busy cycles", n, 8);
        checkVal("timeout data_ack", data_ack, 1);
        checkVal("timeout bus_err", bus_err, 1);
        checkVal("timeout data_rdata", data_rdata, 0);
        checkVal("timeout inst_ack", inst_ack, 0);
        lastData = '0;
        data_req = 1'b0;
        tick();
        checkVal("timeout err drop", bus_err, 0);
        checkVal("timeout ack drop", data_ack, 0);
        checkVal("timeout idle bus_req", bus_req, 0);

        // bus_ack in the last window cycle beats the abort
        data_req = 1'b1;
        data_addr = 32'h0000_0304;
        tick();
        repeat (7) tick();
        checkVal("edge bus_req", bus_req, 1);
        bus_ack = 1'b1;
        bus_rdata = 32'h0000_0055;
        tick();
        bus_ack = 1'b0;
        bus_rdata = '0;
        checkVal("edge data_ack", data_ack, 1);
        checkVal("edge bus_err", bus_err, 0);
        checkVal("edge data_rdata", data_rdata, 32'h55);
        data_req = 1'b0;
        tick();

        // Reset while BUSY
        data_req = 1'b1;
        data_addr = 32'h0000_0308;
        tick();
        checkVal("rstbusy bus_req", bus_req, 1);
        #1 rst = 1'b1;
        #1;
        checkVal("rstbusy async drop", bus_req, 0);
        data_req = 1'b0;
        tick();
        rst = 1'b0;
        bus_ack = 1'b1;
        bus_rdata = 32'h0000_0099;
        tick();
        bus_ack = 1'b0;
        bus_rdata = '0;
        checkVal("rstbusy data_ack", data_ack, 0);
        checkVal("rstbusy inst_ack", inst_ack, 0);
        checkVal("rstbusy bus_err", bus_err, 0);
        checkVal("rstbusy bus_req", bus_req, 0);
        checkVal("rstbusy data_rdata", data_rdata, 0);
        tick();
        checkVal("rstbusy late ack", data_ack, 0);
        checkVal("rstbusy late err", bus_err, 0);
        lastData = '0;
        inst_req = 1'b1;
        inst_addr = 32'h0000_0400;
        doTxn("after rst", 1'b0, 1'b0, 32'h0000_0400, 32'h0, 32'h0BAD_F00D, 2);
        inst_req = 1'b0;
        tick();

        // Back-to-back fetches, request held
        inst_req = 1'b1;
        inst_addr = 32'h0000_0500;
        prevRise = 0;
        for (int k = 0; k < 3; k++) begin
            doTxn($sformatf("b2b%0d", k), 1'b0, 1'b0, 32'h0000_0500, 32'h0, 32'hC000_0000 + k, 1);
            if (k > 0) checkVal($sformatf("b2b%0d spacing", k), riseCyc - prevRise, 3);
            prevRise = riseCyc;
            if (k == 2) inst_req = 1'b0;
            tick();
            checkVal($sformatf("b2b%0d idle bus_req", k), bus_req, 0);
        end
        tick();
        checkVal("b2b final idle", bus_req, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
